// File: rtl/vram_pkg.sv
// Shared types for the VRAM arbiter: pixel/address widths, host command payload and FSM states.
package vram_pkg;
    localparam int unsigned DATA_W = 12;
    localparam int unsigned ROW_W  = 9;
    localparam int unsigned COL_W  = 10;
    localparam int unsigned ADDR_W = ROW_W + COL_W;

    typedef struct packed {
        logic              we;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        HOST     = 2'd1,
        VGA_HOLD = 2'd2
    } state_t;
endpackage

// File: rtl/vram_cmd_fifo.sv
// In-order host command queue; pointers wrap by DEPTH, occupancy kept in its own counter.
module vram_cmd_fifo
    import vram_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned LVL_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  cmd_t             wr_cmd,
    output cmd_t             head,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);
    cmd_t             mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             do_push, do_pop;

    assign full  = (level_q == LVL_W'(DEPTH));
    assign empty = (level_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign level = level_q;

    always_comb begin
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage carries no reset; validity is tracked by the level counter.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_cmd;
    end
endmodule

// File: rtl/vram_arbiter.sv
// Single-port pixel RAM arbiter: VGA scan-out has absolute priority, queued host
// commands drain one per cycle whenever the VGA read strobe is idle.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter  int unsigned FIFO_DEPTH = 4,
    parameter  int unsigned CNT_W      = 16,
    localparam int unsigned LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     vga_rdn,
    input  logic [ROW_W-1:0]         vga_row,
    input  logic [COL_W-1:0]         vga_col,
    output logic [DATA_W-1:0]        vga_din,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_we,
    input  logic [ROW_W-1:0]         cmd_row,
    input  logic [COL_W-1:0]         cmd_col,
    input  logic [DATA_W-1:0]        cmd_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic [ROW_W+COL_W-1:0]   ram_addr,
    output logic                     ram_we,
    output logic [DATA_W-1:0]        ram_wdata,
    input  logic [DATA_W-1:0]        ram_rdata,
    output logic [LVL_W-1:0]         fifo_level,
    output logic [CNT_W-1:0]         stall_cnt,
    output logic [1:0]               state
);
    cmd_t              head, wr_cmd;
    logic              fifo_full, fifo_empty, push, pop;
    logic              ready_en_q;
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [LVL_W-1:0]  level_nxt;

    // ready_en_q keeps the port closed until the first clock after reset.
    assign cmd_ready = ready_en_q && !fifo_full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = vga_rdn && !fifo_empty;
    assign wr_cmd    = '{we: cmd_we, row: cmd_row, col: cmd_col, wdata: cmd_wdata};

    vram_cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .push   (push),
        .pop    (pop),
        .wr_cmd (wr_cmd),
        .head   (head),
        .level  (fifo_level),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // RAM port mux, host response capture, stall counting and next state.
    always_comb begin
        ram_addr    = '0;
        ram_we      = 1'b0;
        ram_wdata   = '0;
        vga_din     = '0;
        stall_cnt_d = stall_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        state_d     = IDLE;
        level_nxt   = fifo_level;

        if (!vga_rdn) begin
            ram_addr = {vga_row, vga_col};
            vga_din  = ram_rdata;
            if (!fifo_empty && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end else if (!fifo_empty) begin
            ram_addr = {head.row, head.col};
            if (head.we) begin
                ram_we    = 1'b1;
                ram_wdata = head.wdata;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_rdata_d = ram_rdata;
            end
        end

        if (push && !pop)      level_nxt = fifo_level + LVL_W'(1);
        else if (pop && !push) level_nxt = fifo_level - LVL_W'(1);

        if (level_nxt != '0) state_d = vga_rdn ? HOST : VGA_HOLD;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ready_en_q  <= 1'b0;
            state_q     <= IDLE;
            stall_cnt_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            ready_en_q  <= 1'b1;
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign state     = state_q;
    assign stall_cnt = stall_cnt_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural pixel RAM, command/response scoreboard,
// a vector table for the basic flow and hand sequences for multi-cycle corners.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CNT_W = 5;
    localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
    localparam int unsigned NVEC  = 21;
    localparam int unsigned SAT   = (1 << CNT_W) - 1;

    logic                clk = 1'b0;
    logic                rst;
    logic                vga_rdn;
    logic [ROW_W-1:0]    vga_row;
    logic [COL_W-1:0]    vga_col;
    logic [DATA_W-1:0]   vga_din;
    logic                cmd_valid;
    logic                cmd_ready;
    logic                cmd_we;
    logic [ROW_W-1:0]    cmd_row;
    logic [COL_W-1:0]    cmd_col;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                rsp_valid;
    logic [DATA_W-1:0]   rsp_rdata;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_we;
    logic [DATA_W-1:0]   ram_wdata;
    logic [DATA_W-1:0]   ram_rdata;
    logic [LVL_W-1:0]    fifo_level;
    logic [CNT_W-1:0]    stall_cnt;
    logic [1:0]          state;

    vram_arbiter #(.FIFO_DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .vga_rdn    (vga_rdn),
        .vga_row    (vga_row),
        .vga_col    (vga_col),
        .vga_din    (vga_din),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_we     (cmd_we),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_wdata  (cmd_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .fifo_level (fifo_level),
        .stall_cnt  (stall_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Pixel RAM model: unwritten locations read back an address-derived pattern.
    logic [DATA_W-1:0] ram_mem [0:(1<<ADDR_W)-1];
    bit                wr_flag [0:(1<<ADDR_W)-1];

    function automatic logic [DATA_W-1:0] pat(input logic [ADDR_W-1:0] a);
        return DATA_W'(a) ^ 12'h5A5;
    endfunction

    assign ram_rdata = wr_flag[ram_addr] ? ram_mem[ram_addr] : pat(ram_addr);

    always @(posedge clk) begin
        if (ram_we) begin
            ram_mem[ram_addr] <= ram_wdata;
            wr_flag[ram_addr] <= 1'b1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard state: expected writes/responses queued at acceptance.
    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t               exp_wr [$];
    logic [DATA_W-1:0] exp_rsp [$];
    logic [DATA_W-1:0] shadow [logic [ADDR_W-1:0]];
    int                mlevel  = 0;
    bit                armed   = 1'b0;
    int                wr_seen = 0;
    int                rsp_seen = 0;
    wr_t               mon_w;
    logic [DATA_W-1:0] mon_r;

    function automatic logic [DATA_W-1:0] shadow_get(input logic [ADDR_W-1:0] a);
        if (shadow.exists(a)) return shadow[a];
        return pat(a);
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (!vga_rdn) begin
                check("vga_addr", 32'(ram_addr), 32'({vga_row, vga_col}));
                check("vga_no_we", 32'(ram_we), 32'(0));
                check("vga_din", 32'(vga_din), 32'(ram_rdata));
            end else begin
                check("vga_din_idle", 32'(vga_din), 32'(0));
            end
            if (ram_we) begin
                wr_seen++;
                check("wr_expected", 32'(exp_wr.size() > 0), 32'(1));
                if (exp_wr.size() > 0) begin
                    mon_w = exp_wr.pop_front();
                    check("wr_addr", 32'(ram_addr), 32'(mon_w.addr));
                    check("wr_data", 32'(ram_wdata), 32'(mon_w.data));
                end
            end
            if (rsp_valid) begin
                rsp_seen++;
                check("rsp_expected", 32'(exp_rsp.size() > 0), 32'(1));
                if (exp_rsp.size() > 0) begin
                    mon_r = exp_rsp.pop_front();
                    check("rsp_rdata", 32'(rsp_rdata), 32'(mon_r));
                end
            end
        end
    end

    // Drive one cycle of inputs just after the edge, then wait for the sampling edge.
    task automatic drive(input logic rdn, input logic valid, input logic we,
                         input logic [ROW_W-1:0] row, input logic [COL_W-1:0] col,
                         input logic [DATA_W-1:0] d);
        vga_rdn   = rdn;
        cmd_valid = valid;
        cmd_we    = we;
        cmd_row   = row;
        cmd_col   = col;
        cmd_wdata = d;
        vga_row   = ROW_W'($urandom);
        vga_col   = COL_W'($urandom);
        @(negedge clk);
    endtask

    // Advance through the active edge and update the reference FIFO model.
    task automatic tick();
        bit acc, pp;
        logic [ADDR_W-1:0] a;
        @(posedge clk);
        acc = armed && cmd_valid && (mlevel < int'(DEPTH));
        pp  = vga_rdn && (mlevel > 0);
        if (acc) begin
            a = {cmd_row, cmd_col};
            if (cmd_we) begin
                exp_wr.push_back('{addr: a, data: cmd_wdata});
                shadow[a] = cmd_wdata;
            end else begin
                exp_rsp.push_back(shadow_get(a));
            end
        end
        mlevel = mlevel + int'(acc) - int'(pp);
        armed  = !rst;
        #1;
    endtask

    typedef struct {
        logic              rdn, valid, we;
        logic [ROW_W-1:0]  row;
        logic [COL_W-1:0]  col;
        logic [DATA_W-1:0] d;
        logic [LVL_W-1:0]  lvl;
        logic              rdy;
        logic [1:0]        st;
        logic              wen, rv;
        logic [CNT_W-1:0]  stall;
    } vec_t;

    vec_t vec [NVEC];

    function automatic vec_t mk(input int rdn, input int valid, input int we, input int row,
                                input int col, input int d, input int lvl, input int rdy,
                                input int st, input int wen, input int rv, input int stall);
        vec_t v;
        v.rdn = 1'(rdn);   v.valid = 1'(valid); v.we = 1'(we);
        v.row = ROW_W'(row); v.col = COL_W'(col); v.d = DATA_W'(d);
        v.lvl = LVL_W'(lvl); v.rdy = 1'(rdy);   v.st = 2'(st);
        v.wen = 1'(wen);   v.rv = 1'(rv);       v.stall = CNT_W'(stall);
        return v;
    endfunction

    int wr_mark, rsp_mark;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            rdn v we row col data   lvl rdy st wen rv stall
        vec[0]  = mk(1, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0, 0);
        vec[1]  = mk(1, 1, 1, 5, 7, 'hABC,  0, 1, 0, 0, 0, 0);
        vec[2]  = mk(1, 1, 0, 5, 7, 0,      1, 1, 1, 1, 0, 0);
        vec[3]  = mk(1, 0, 0, 0, 0, 0,      1, 1, 1, 0, 0, 0);
        vec[4]  = mk(1, 0, 0, 0, 0, 0,      0, 1, 0, 0, 1, 0);
        vec[5]  = mk(1, 0, 0, 0, 0, 0,      0, 1, 0, 0, 0, 0);
        vec[6]  = mk(0, 1, 1, 1, 1, 'h111,  0, 1, 0, 0, 0, 0);
        vec[7]  = mk(0, 1, 1, 2, 2, 'h222,  1, 1, 2, 0, 0, 0);
        vec[8]  = mk(0, 1, 1, 3, 3, 'h333,  2, 1, 2, 0, 0, 1);
        vec[9]  = mk(0, 1, 0, 1, 1, 0,      3, 1, 2, 0, 0, 2);
        vec[10] = mk(0, 1, 1, 9, 9, 'hEEE,  4, 0, 2, 0, 0, 3);
        vec[11] = mk(0, 0, 0, 0, 0, 0,      4, 0, 2, 0, 0, 4);
        vec[12] = mk(0, 0, 0, 0, 0, 0,      4, 0, 2, 0, 0, 5);
        vec[13] = mk(0, 0, 0, 0, 0, 0,      4, 0, 2, 0, 0, 6);
        vec[14] = mk(0, 0, 0, 0, 0, 0,      4, 0, 2, 0, 0, 7);
        vec[15] = mk(0, 0, 0, 0, 0, 0,      4, 0, 2, 0, 0, 8);
        vec[16] = mk(1, 0, 0, 0, 0, 0,      4, 0, 2, 1, 0, 9);
        vec[17] = mk(1, 0, 0, 0, 0, 0,      3, 1, 1, 1, 0, 9);
        vec[18] = mk(1, 0, 0, 0, 0, 0,      2, 1, 1, 1, 0, 9);
        vec[19] = mk(1, 0, 0, 0, 0, 0,      1, 1, 1, 0, 0, 9);
        vec[20] = mk(1, 0, 0, 0, 0, 0,      0, 1, 0, 0, 1, 9);

        rst = 1'b1; vga_rdn = 1'b1; vga_row = '0; vga_col = '0;
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_row = '0; cmd_col = '0; cmd_wdata = '0;

        #12;
        check("rst_ready", 32'(cmd_ready), 32'(0));
        check("rst_level", 32'(fifo_level), 32'(0));
        check("rst_state", 32'(state), 32'(0));
        check("rst_we", 32'(ram_we), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_stall", 32'(stall_cnt), 32'(0));
        #10 rst = 1'b0;
        #1 check("ready_before_clk", 32'(cmd_ready), 32'(0));
        @(posedge clk); #1;
        armed = 1'b1;
        check("ready_after_clk", 32'(cmd_ready), 32'(1));

        // Write/read ordering, fill to full under VGA stall, then drain.
        for (int i = 0; i < int'(NVEC); i++) begin
            drive(vec[i].rdn, vec[i].valid, vec[i].we, vec[i].row, vec[i].col, vec[i].d);
            check($sformatf("v%0d_level", i), 32'(fifo_level), 32'(vec[i].lvl));
            check($sformatf("v%0d_ready", i), 32'(cmd_ready), 32'(vec[i].rdy));
            check($sformatf("v%0d_state", i), 32'(state), 32'(vec[i].st));
            check($sformatf("v%0d_ram_we", i), 32'(ram_we), 32'(vec[i].wen));
            check($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'(vec[i].rv));
            check($sformatf("v%0d_stall", i), 32'(stall_cnt), 32'(vec[i].stall));
            tick();
        end

        // Three writes queued under VGA, then alternating strobe: writes only in free cycles.
        wr_mark = wr_seen;
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b1, ROW_W'(10 + i), COL_W'(20 + i), DATA_W'(12'h700 + i));
            tick();
        end
        for (int i = 0; i < 6; i++) begin
            drive((i % 2) == 0, 1'b0, 1'b0, '0, '0, '0);
            tick();
        end
        check("alt_writes", 32'(wr_seen - wr_mark), 32'(3));
        check("alt_stall", 32'(stall_cnt), 32'(13));
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, 1'b0, ROW_W'(10 + i), COL_W'(20 + i), '0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
            tick();
        end
        check("alt_rsp_drained", 32'(exp_rsp.size()), 32'(0));

        // Asynchronous reset with three reads queued and one at the head.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, ROW_W'(40 + i), COL_W'(50 + i), '0);
            tick();
        end
        wr_mark  = wr_seen;
        rsp_mark = rsp_seen;
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("pre_rst_level", 32'(fifo_level), 32'(3));
        #2 rst = 1'b1;
        #1;
        check("arst_level", 32'(fifo_level), 32'(0));
        check("arst_ready", 32'(cmd_ready), 32'(0));
        check("arst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("arst_state", 32'(state), 32'(0));
        check("arst_stall", 32'(stall_cnt), 32'(0));
        exp_wr.delete();
        exp_rsp.delete();
        mlevel = 0;
        armed  = 1'b0;
        @(posedge clk); #1;
        check("arst_hold_rsp", 32'(rsp_valid), 32'(0));
        @(posedge clk); #3;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
            tick();
        end
        check("post_rst_no_we", 32'(wr_seen - wr_mark), 32'(0));
        check("post_rst_no_rsp", 32'(rsp_seen - rsp_mark), 32'(0));
        check("post_rst_level", 32'(fifo_level), 32'(0));

        // Hold VGA ownership with a queued write until the stall counter saturates.
        drive(1'b0, 1'b1, 1'b1, ROW_W'(100), COL_W'(200), DATA_W'(12'h3C3));
        tick();
        for (int k = 1; k <= int'(SAT) + 5; k++) begin
            drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
            check($sformatf("stall_k%0d", k), 32'(stall_cnt), 32'((k - 1 > int'(SAT)) ? int'(SAT) : k - 1));
            tick();
        end
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("sat_drain_we", 32'(ram_we), 32'(1));
        tick();
        drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
        check("sat_hold", 32'(stall_cnt), 32'(SAT));
        tick();

        check("end_wr_queue", 32'(exp_wr.size()), 32'(0));
        check("end_rsp_queue", 32'(exp_rsp.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
